// File: rtl/ringosc_freq_meter.sv
// Gated edge counter: synchronizes an asynchronous ring-oscillator tap into clk,
// counts its rising edges over a programmable clk window and holds the result.
module ringosc_freq_meter #(
  parameter int COUNT_WIDTH = 24,
  parameter int GATE_WIDTH  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   osc_in,
  input  logic                   start,
  input  logic [GATE_WIDTH-1:0]  gate_cycles,
  output logic                   busy,
  output logic                   done,
  output logic                   overflow,
  output logic [COUNT_WIDTH-1:0] count,
  input  logic [1:0]             rd_sel,
  output logic [7:0]             rd_data
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_MEAS = 1'b1;
  localparam logic [COUNT_WIDTH-1:0] CNT_MAX = {COUNT_WIDTH{1'b1}};

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   hist_q, hist_d;
  logic [0:0]             state_q, state_d;
  logic [GATE_WIDTH-1:0]  win_q, win_d;
  logic [COUNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                   ovf_run_q, ovf_run_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic                   done_q, done_d;
  logic                   ovf_q, ovf_d;

  logic                   edge_pulse;
  logic                   sat_hit;
  logic [COUNT_WIDTH-1:0] cnt_next;
  logic [31:0]            count_ext;

  // Synchronizer and history run free of the FSM, even in IDLE.
  assign sync_d     = {sync_q[SYNC_STAGES-2:0], osc_in};
  assign hist_d     = sync_q[SYNC_STAGES-1];
  assign edge_pulse = sync_q[SYNC_STAGES-1] & ~hist_q;

  assign sat_hit  = edge_pulse && (cnt_q == CNT_MAX);
  assign cnt_next = (edge_pulse && (cnt_q != CNT_MAX)) ? cnt_q + COUNT_WIDTH'(1) : cnt_q;

  always_comb begin
    state_d   = state_q;
    win_d     = win_q;
    cnt_d     = cnt_q;
    ovf_run_d = ovf_run_q;
    count_d   = count_q;
    done_d    = done_q;
    ovf_d     = ovf_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          ovf_d = 1'b0;
          if (gate_cycles != '0) begin
            win_d     = gate_cycles;
            cnt_d     = '0;
            ovf_run_d = 1'b0;
            done_d    = 1'b0;
            state_d   = S_MEAS;
          end else begin
            count_d = '0;
            done_d  = 1'b1;
          end
        end
      end
      default: begin
        cnt_d     = cnt_next;
        ovf_run_d = ovf_run_q | sat_hit;
        win_d     = win_q - GATE_WIDTH'(1);
        // Last window cycle: publish including this cycle's edge.
        if (win_q == GATE_WIDTH'(1)) begin
          count_d = cnt_next;
          ovf_d   = ovf_run_q | sat_hit;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q    <= '0;
      hist_q    <= 1'b0;
      state_q   <= S_IDLE;
      win_q     <= '0;
      cnt_q     <= '0;
      ovf_run_q <= 1'b0;
      count_q   <= '0;
      done_q    <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      hist_q    <= hist_d;
      state_q   <= state_d;
      win_q     <= win_d;
      cnt_q     <= cnt_d;
      ovf_run_q <= ovf_run_d;
      count_q   <= count_d;
      done_q    <= done_d;
      ovf_q     <= ovf_d;
    end
  end

  assign busy     = (state_q == S_MEAS);
  assign done     = done_q;
  assign overflow = ovf_q;
  assign count    = count_q;

  assign count_ext = 32'(count_q);
  always_comb begin
    case (rd_sel)
      2'd0:    rd_data = count_ext[7:0];
      2'd1:    rd_data = count_ext[15:8];
      2'd2:    rd_data = count_ext[23:16];
      default: rd_data = count_ext[31:24];
    endcase
  end

endmodule

// File: tb/tb_ringosc_freq_meter.sv
// Randomized bench for ringosc_freq_meter: a 24-bit and a 4-bit instance share
// stimulus and are checked every cycle against an edge-counting reference model.
module tb_ringosc_freq_meter;
  localparam int N  = 2;
  localparam int GW = 16;

  logic clk, rst_n, osc_in, start;
  logic [GW-1:0] gate_cycles;
  logic [1:0] rd_sel;
  logic busy_a, done_a, ovf_a, busy_b, done_b, ovf_b;
  logic [23:0] count_a;
  logic [3:0]  count_b;
  logic [7:0]  rd_a, rd_b;

  ringosc_freq_meter #(.COUNT_WIDTH(24), .GATE_WIDTH(GW), .SYNC_STAGES(N)) dut (
    .clk(clk), .rst_n(rst_n), .osc_in(osc_in), .start(start), .gate_cycles(gate_cycles),
    .busy(busy_a), .done(done_a), .overflow(ovf_a), .count(count_a),
    .rd_sel(rd_sel), .rd_data(rd_a));

  ringosc_freq_meter #(.COUNT_WIDTH(4), .GATE_WIDTH(GW), .SYNC_STAGES(N)) dut4 (
    .clk(clk), .rst_n(rst_n), .osc_in(osc_in), .start(start), .gate_cycles(gate_cycles),
    .busy(busy_b), .done(done_b), .overflow(ovf_b), .count(count_b),
    .rd_sel(rd_sel), .rd_data(rd_b));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Oscillator source: square wave of period osc_per, or random bits.
  int osc_mode = 0;
  int osc_per  = 4;
  int phase    = 0;
  always @(negedge clk) begin
    phase++;
    if (osc_mode == 0) osc_in = ((phase % osc_per) < (osc_per / 2));
    else               osc_in = 1'($urandom_range(0, 1));
  end

  // Reference model: samples of osc_in per clk edge; a window's result is the
  // number of 0->1 transitions in the sample stream, delayed by N edges.
  bit s [0:131071];
  int k = 16;
  bit pending = 0;
  int win_beg, win_end;
  bit exp_busy = 0, exp_done = 0, exp_ovf_a = 0, exp_ovf_b = 0;
  int exp_cnt_a = 0, exp_cnt_b = 0;

  function automatic int edges_in(input int a, input int b);
    int n = 0;
    for (int j = a; j <= b; j++) if (s[j-N] && !s[j-N-1]) n++;
    return n;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = k - 8; j <= k; j++) s[j] = 1'b0;
      pending = 0; exp_busy = 0; exp_done = 0;
      exp_ovf_a = 0; exp_ovf_b = 0; exp_cnt_a = 0; exp_cnt_b = 0;
    end else begin
      bit was_busy;
      int raw;
      k++;
      s[k] = osc_in;
      was_busy = pending && (k <= win_end);
      if (pending && k == win_end) begin
        raw = edges_in(win_beg + 1, win_end);
        exp_cnt_a = (raw > 24'hFFFFFF) ? 24'hFFFFFF : raw;
        exp_ovf_a = (raw > 24'hFFFFFF);
        exp_cnt_b = (raw > 15) ? 15 : raw;
        exp_ovf_b = (raw > 15);
        exp_done = 1; pending = 0;
      end
      if (start && !was_busy) begin
        exp_ovf_a = 0; exp_ovf_b = 0;
        if (gate_cycles == 0) begin
          exp_cnt_a = 0; exp_cnt_b = 0; exp_done = 1;
        end else begin
          pending = 1; win_beg = k; win_end = k + int'(gate_cycles); exp_done = 0;
        end
      end
      exp_busy = pending && (k < win_end);
    end
  end

  function automatic logic [7:0] byte_of(input int v, input logic [1:0] sel);
    logic [31:0] w;
    w = v;
    return w[8*sel +: 8];
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      chk("busy_a", busy_a, exp_busy);
      chk("done_a", done_a, exp_done);
      chk("ovf_a", ovf_a, exp_ovf_a);
      chk("count_a", count_a, exp_cnt_a);
      chk("rd_a", rd_a, byte_of(exp_cnt_a, rd_sel));
      chk("busy_b", busy_b, exp_busy);
      chk("done_b", done_b, exp_done);
      chk("ovf_b", ovf_b, exp_ovf_b);
      chk("count_b", count_b, exp_cnt_b);
      chk("rd_b", rd_b, byte_of(exp_cnt_b, rd_sel));
    end
  end

  // Called at a negedge: pulses start, then follows the window until done.
  // Returns at the negedge where done is first seen.
  task automatic run_window(input int g, input int ign_at, input int ign_gate,
                            input bit rnd_sel, output int busy_cnt);
    bit seen = 0;
    busy_cnt = 0;
    start = 1'b1; gate_cycles = GW'(g);
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < g + 20; i++) begin
      if (busy_a) busy_cnt++;
      if (done_a) begin seen = 1; break; end
      if (i == ign_at) begin start = 1'b1; gate_cycles = GW'(ign_gate); end
      else start = 1'b0;
      if (rnd_sel) rd_sel = 2'($urandom_range(0, 3));
      @(negedge clk);
    end
    start = 1'b0;
    if (!seen) chk("window_timeout", 32'd0, 32'd1);
  endtask

  int bc;

  initial begin
    rst_n = 1'b0; start = 1'b0; gate_cycles = '0; rd_sel = 2'd0; osc_in = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy_a, 0); chk("rst_done", done_a, 0);
    chk("rst_count", count_a, 0); chk("rst_rd", rd_a, 0);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);

    // Nominal: period-4 square wave, 100-cycle window.
    run_window(100, -1, 0, 0, bc);
    chk("nom_busy_len", bc, 100);
    chk("nom_count", count_a, 25);
    chk("nom_ovf", ovf_a, 0);
    rd_sel = 2'd0; #1 chk("nom_rd0", rd_a, 8'h19);
    rd_sel = 2'd1; #1 chk("nom_rd1", rd_a, 8'h00);
    @(negedge clk);

    // Zero-length window.
    run_window(0, -1, 0, 0, bc);
    chk("zero_busy", bc, 0);
    chk("zero_done", done_a, 1);
    chk("zero_count", count_a, 0);
    @(negedge clk);

    // Saturation on the 4-bit instance, then recovery.
    osc_per = 2;
    repeat (5) @(negedge clk);
    run_window(40, -1, 0, 0, bc);
    chk("sat_count4", count_b, 15);
    chk("sat_ovf4", ovf_b, 1);
    chk("sat_count24", count_a, 20);
    @(negedge clk);
    run_window(4, -1, 0, 0, bc);
    chk("rec_count4", count_b, 2);
    chk("rec_ovf4", ovf_b, 0);

    // Start during a window is ignored.
    osc_per = 4;
    @(negedge clk);
    run_window(50, 9, 7, 0, bc);
    chk("ign_busy_len", bc, 50);

    // Back-to-back: restart in the first cycle done is visible.
    run_window(20, -1, 0, 0, bc);
    start = 1'b1; gate_cycles = GW'(12);
    @(negedge clk);
    start = 1'b0;
    chk("b2b_done_drop", done_a, 0);
    chk("b2b_busy", busy_a, 1);
    repeat (15) @(negedge clk);

    // Randomized windows with random oscillator, extra starts and readback.
    osc_mode = 1;
    for (int w = 0; w < 30; w++) begin
      int g = $urandom_range(0, 60);
      run_window(g, $urandom_range(0, 70), $urandom_range(0, 9), 1, bc);
      chk("rnd_busy_len", bc, g);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    // Asynchronous reset mid-window.
    osc_mode = 0;
    start = 1'b1; gate_cycles = GW'(1000);
    @(negedge clk);
    start = 1'b0;
    repeat (100) @(negedge clk);
    chk("pre_rst_busy", busy_a, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", busy_a, 0); chk("arst_done", done_a, 0);
    chk("arst_ovf", ovf_a, 0); chk("arst_count", count_a, 0);
    chk("arst_rd", rd_a, 0); chk("arst_count4", count_b, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("post_rst_busy", busy_a, 0);
    chk("post_rst_done", done_a, 0);
    run_window(8, -1, 0, 0, bc);
    chk("post_rst_busy_len", bc, 8);
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/ringosc_freq_meter.md
# ringosc_freq_meter

Gated edge counter that measures the frequency of one divided tap of the giant ring oscillator against the system clock. It synchronizes the free-running, asynchronous oscillator signal into `clk`. It counts rising edges over a programmable window of `clk` cycles and holds the result for byte-wide readback over the spare TT I/O. It is the on-chip reader for the oscillator taps, so an external scope is no longer needed.

## Interface

Parameters:
- `COUNT_WIDTH`, 24: width of edge counter and result; values 4..32.
- `GATE_WIDTH`, 16: width of window length input.
- `SYNC_STAGES`, 2: synchronizer flops on `osc_in`; values 2..4.

Ports:
- `clk`  input  1  system clock; all state on rising edge.
- `rst_n`  input  1  asynchronous, active-low reset; deassertion is synchronous to `clk` upstream.
- `osc_in`  input  1  asynchronous oscillator tap; max toggle rate below `clk`/2.
- `start`  input  1  one-cycle request to begin a measurement.
- `gate_cycles`  input  GATE_WIDTH  window length in `clk` cycles; sampled only when `start` is accepted.
- `busy`  output  1  high while a window is open.
- `done`  output  1  sticky; result valid.
- `overflow`  output  1  sticky per measurement; counter saturated.
- `count`  output  COUNT_WIDTH  held result of the last completed measurement.
- `rd_sel`  input  2  byte select for readback.
- `rd_data`  output  8  byte `rd_sel` of `count`, zero-extended past COUNT_WIDTH; combinational from the held result.

## Operation

- Synchronizer: a chain of SYNC_STAGES flops followed by one history flop. A rising edge is detected when the last sync stage is 1 and the history flop is 0, one pulse per edge.
- FSM states:
  - IDLE: `busy`=0.
    - `start`=1 with `gate_cycles`≠0: load window counter = `gate_cycles`, clear edge counter and overflow, clear `done`, go to MEASURE.
    - `start`=1 with `gate_cycles`=0: `count`←0, `overflow`←0, `done`←1, stay IDLE.
  - MEASURE: `busy`=1.
    - Each cycle: edge pulse → edge counter +1, saturating at all-ones.
    - An increment attempted at all-ones sets `overflow`.
    - The window counter decrements each cycle.
    - In the cycle where the window counter = 1: `count`←edge counter (including that cycle's edge), `done`←1, go to IDLE.
- `start` during MEASURE is ignored entirely: no restart, and `gate_cycles` is not resampled.
- `count`, `overflow` and `done` hold until the next accepted `start`.
- Edges detected in the `start` cycle are not counted.
- Synchronizer flops run continuously, including in IDLE.
- Reset (any time, including mid-window):
  - State = IDLE; `busy`, `done`, `overflow` = 0; `count`=0; `rd_data`=0.
  - Synchronizer and history flops = 0.
  - The window is abandoned and no partial result is published.

## Timing

- `start` accepted in cycle T. MEASURE occupies cycles T+1..T+G, where G = `gate_cycles` (exactly G cycles of counting).
- `busy` is high from T+1 through T+G. `done`, `count` and `overflow` update at the clock edge ending T+G and are visible from T+G+1.
- For G=0: `done`=1 and `count`=0 are visible at T+1; `busy` never rises.
- Detection latency from `osc_in` pin edge to counted pulse is SYNC_STAGES+1 cycles. This latency is a constant offset and does not change the window length.
- Per-window quantization error is ±1 edge.
- Back-to-back operation: `start` in cycle T+G+1 is accepted and clears `done` at T+G+2.
- `rd_data` follows `rd_sel` with zero latency.
  - `rd_sel`=0 → bits 7:0; 1 → 15:8; 2 → 23:16; 3 → 31:24.

## Test plan

- Reset: assert `rst_n`=0 mid-window with G=1000 → all outputs 0 immediately (async). After release, `busy`=0 and `done`=0 until the next `start`.
- Nominal: `osc_in` driven as a clk-synchronous square wave, period 4 cycles; `start` with G=100 → `busy` high exactly 100 cycles, then `done`=1, `count`=25, `overflow`=0. Readback: `rd_sel`=0 → 0x19, `rd_sel`=1 → 0x00.
- Zero window: `start` with G=0 → `done`=1 and `count`=0 next cycle; `busy` never high.
- Saturation: COUNT_WIDTH=4, `osc_in` period 2 cycles, G=40 → `count`=15, `overflow`=1. Next `start` with G=4 → `overflow`=0, `count`=2.
- Ignored start: `start` pulsed at T+10 of a G=50 window with `gate_cycles`=7 → window still ends at T+50; result reflects 50 cycles.
- Back-to-back: second `start` in the first cycle after `done` rises → `done` drops one cycle later and the second result is independent of the first (counter cleared).
